// File: rtl/store_rmw_unit.sv
// Store read-modify-write unit: merges sub-word stores into a memory word,
// issuing a read only when the store does not cover the whole word.

module store_rmw_byte_lane #(
  parameter int NB    = 4,
  parameter int LANE  = 0,
  parameter int OFF_W = 2
)(
  input  logic [7:0]         old_byte,
  input  logic [NB-1:0][7:0] data,
  input  logic [OFF_W-1:0]   off,
  input  logic [1:0]         size,
  output logic [7:0]         new_byte
);
  int rel;

  // rel is this lane's byte index inside the store; out of range keeps memory byte
  always_comb begin
    rel      = LANE - int'(off);
    new_byte = old_byte;
    if (rel >= 0 && rel < (1 << size)) new_byte = data[rel[OFF_W-1:0]];
  end
endmodule

module store_rmw_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1
)(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic [1:0]        req_size_i,
  output logic              mem_rd_en_o,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic [DATA_W-1:0] mem_wr_data_o,
  output logic              done_o,
  output logic              err_o
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, ERR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [1:0]          size_q;
  logic [RD_LAT-1:0]   vld_pipe;
  logic [OFF_W-1:0]    req_off, size_mask;
  logic                misaligned, full;
  logic [NB-1:0][7:0]  rd_bytes, data_bytes, merged;

  assign req_off = req_addr_i[OFF_W-1:0];

  always_comb begin
    size_mask = '0;
    for (int i = 0; i < OFF_W; i++) size_mask[i] = (int'(req_size_i) > i);
  end

  assign misaligned = (int'(req_size_i) > OFF_W) || ((req_off & size_mask) != '0);
  assign full       = (int'(req_size_i) == OFF_W);

  assign rd_bytes   = mem_rd_data_i;
  assign data_bytes = data_q;

  for (genvar g = 0; g < NB; g++) begin : g_lane
    store_rmw_byte_lane #(.NB(NB), .LANE(g), .OFF_W(OFF_W)) u_lane (
      .old_byte (rd_bytes[g]),
      .data     (data_bytes),
      .off      (addr_q[OFF_W-1:0]),
      .size     (size_q),
      .new_byte (merged[g])
    );
  end

  assign mem_addr_o = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      req_ready_o   <= 1'b0;
      mem_rd_en_o   <= 1'b0;
      mem_wr_en_o   <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      size_q        <= '0;
      vld_pipe      <= '0;
      mem_wr_data_o <= '0;
    end else begin
      mem_rd_en_o <= 1'b0;
      mem_wr_en_o <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      case (state)
        IDLE: begin
          req_ready_o <= 1'b1;
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            addr_q      <= req_addr_i;
            data_q      <= req_data_i;
            size_q      <= req_size_i;
            if (misaligned) begin
              state  <= ERR;
              done_o <= 1'b1;
              err_o  <= 1'b1;
            end else if (full) begin
              state         <= WRITE;
              mem_wr_en_o   <= 1'b1;
              done_o        <= 1'b1;
              mem_wr_data_o <= req_data_i;
            end else begin
              state       <= READ;
              mem_rd_en_o <= 1'b1;
            end
          end
        end
        READ: begin
          state    <= WAIT;
          vld_pipe <= RD_LAT'(1);
        end
        WAIT: begin
          // top pipe bit marks the cycle the read data is valid
          if (vld_pipe[RD_LAT-1]) begin
            state         <= WRITE;
            mem_wr_en_o   <= 1'b1;
            done_o        <= 1'b1;
            mem_wr_data_o <= merged;
          end else begin
            vld_pipe <= vld_pipe << 1;
          end
        end
        WRITE, ERR: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: a 32-bit/RD_LAT=1 and a 64-bit/RD_LAT=3 instance,
// directed table, reset corner cases, then random stores against a byte-level model.

module tb_store_rmw_unit;
  logic        clk, rst_n;
  logic [1:0]  req_valid, ready, rd_en, wr_en, done, err;
  logic [31:0] req_addr [2];
  logic [63:0] req_data [2];
  logic [1:0]  req_size [2];
  logic [31:0] addr32, addr64, wd32, rdd32;
  logic [63:0] wd64, rdd64;
  logic [63:0] mem_word [2];
  int          nvec, nfail, cyc;
  int          rd_cyc [2];

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [63:0] d;
    logic [1:0]  sz;
    logic [63:0] m;
    logic [63:0] wd;
    bit          e;
    int          lat;
  } vec_t;

  vec_t tbl [8];

  store_rmw_unit #(.DATA_W(32), .ADDR_W(32), .RD_LAT(1)) u32 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid[0]), .req_ready_o(ready[0]),
    .req_addr_i(req_addr[0]), .req_data_i(req_data[0][31:0]), .req_size_i(req_size[0]),
    .mem_rd_en_o(rd_en[0]), .mem_wr_en_o(wr_en[0]), .mem_addr_o(addr32),
    .mem_rd_data_i(rdd32), .mem_wr_data_o(wd32), .done_o(done[0]), .err_o(err[0]));

  store_rmw_unit #(.DATA_W(64), .ADDR_W(32), .RD_LAT(3)) u64 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid[1]), .req_ready_o(ready[1]),
    .req_addr_i(req_addr[1]), .req_data_i(req_data[1]), .req_size_i(req_size[1]),
    .mem_rd_en_o(rd_en[1]), .mem_wr_en_o(wr_en[1]), .mem_addr_o(addr64),
    .mem_rd_data_i(rdd64), .mem_wr_data_o(wd64), .done_o(done[1]), .err_o(err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: read data is valid only in the cycle exactly RD_LAT after the strobe
  always @(negedge clk) begin
    cyc++;
    rdd32 = (cyc == rd_cyc[0] + 1) ? mem_word[0][31:0] : $urandom;
    rdd64 = (cyc == rd_cyc[1] + 3) ? mem_word[1] : {$urandom, $urandom};
    if (rd_en[0]) rd_cyc[0] = cyc;
    if (rd_en[1]) rd_cyc[1] = cyc;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input bit s, input logic [31:0] a, input logic [63:0] d,
                                input logic [1:0] sz, input logic [63:0] m,
                                output logic [63:0] wd, output bit e, output int lat);
    int nb, off, n;
    logic [7:0] b [8];
    nb  = s ? 8 : 4;
    off = int'(a[2:0]) % nb;
    n   = 1 << sz;
    e   = (n > nb) || (off % n != 0);
    for (int i = 0; i < 8; i++) b[i] = m[8*i +: 8];
    if (!e) for (int i = 0; i < n; i++) b[off+i] = d[8*i +: 8];
    wd = '0;
    for (int i = 0; i < nb; i++) wd[8*i +: 8] = b[i];
    lat = e ? 1 : (n == nb) ? 1 : 2 + (s ? 3 : 1);
  endfunction

  task automatic run_txn(input bit s, input logic [31:0] a, input logic [63:0] d,
                         input logic [1:0] sz, input logic [63:0] m, input logic [63:0] ewd,
                         input bit eerr, input int elat);
    int got_lat, nrd, nwr;
    bit gerr;
    logic [63:0] gwd;
    logic [31:0] gaddr, ealign;
    got_lat = 0; nrd = 0; nwr = 0; gerr = 0; gwd = '0; gaddr = '0;
    ealign = s ? {a[31:3], 3'b0} : {a[31:2], 2'b0};
    @(negedge clk);
    chk("ready_before_req", ready[s], 1);
    mem_word[s] = m;
    req_addr[s] = a; req_data[s] = d; req_size[s] = sz; req_valid[s] = 1'b1;
    @(posedge clk); #1;
    // junk stays valid while busy: must be neither latched nor accepted
    req_addr[s] = $urandom; req_data[s] = {$urandom, $urandom}; req_size[s] = 2'($urandom);
    for (int k = 1; k <= 8 && got_lat == 0; k++) begin
      @(negedge clk);
      nrd += int'(rd_en[s]);
      nwr += int'(wr_en[s]);
      if (done[s]) begin
        got_lat = k; gerr = err[s];
        gwd   = s ? wd64 : {32'h0, wd32};
        gaddr = s ? addr64 : addr32;
        req_valid[s] = 1'b0;
      end
    end
    req_valid[s] = 1'b0;
    chk("done_latency", got_lat, elat);
    chk("err_flag", gerr, eerr);
    chk("rd_strobes", nrd, (!eerr && elat > 1) ? 1 : 0);
    chk("wr_strobes", nwr, eerr ? 0 : 1);
    if (!eerr) begin
      chk("wr_data", gwd, ewd);
      chk("mem_addr", gaddr, ealign);
    end
  endtask

  initial begin
    bit s, e;
    int lat;
    logic [1:0] sz;
    logic [31:0] a;
    logic [63:0] d, m, wd;

    nvec = 0; nfail = 0; cyc = 0;
    rd_cyc[0] = -100; rd_cyc[1] = -100;
    req_valid = '0;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = '0; req_data[i] = '0; req_size[i] = '0; mem_word[i] = '0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    tbl[0] = '{0, 32'h1001, 64'hAB,               2'd0, 64'h11223344,         64'h1122AB44,         0, 3};
    tbl[1] = '{0, 32'h2002, 64'hBEEF,             2'd1, 64'h11223344,         64'hBEEF3344,         0, 3};
    tbl[2] = '{0, 32'h3000, 64'hDEADBEEF,         2'd2, 64'h0,                64'hDEADBEEF,         0, 1};
    tbl[3] = '{0, 32'h4001, 64'h1234,             2'd1, 64'h0,                64'h0,                1, 1};
    tbl[4] = '{0, 32'h5000, 64'h1234,             2'd3, 64'h0,                64'h0,                1, 1};
    tbl[5] = '{1, 32'h6007, 64'h5A,               2'd0, 64'h0123456789ABCDEF, 64'h5A23456789ABCDEF, 0, 5};
    tbl[6] = '{1, 32'h7008, 64'h1122334455667788, 2'd3, 64'h0,                64'h1122334455667788, 0, 1};
    tbl[7] = '{1, 32'h7004, 64'hCAFEF00D,         2'd2, 64'h0123456789ABCDEF, 64'hCAFEF00D89ABCDEF, 0, 5};

    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 2'b00);
    chk("rst_strobes", {rd_en, wr_en, done, err}, 8'h00);
    chk("rst_outputs", {addr32, addr64, wd32}, 96'h0);
    chk("rst_wd64", wd64, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", ready, 2'b11);

    foreach (tbl[i])
      run_txn(tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].sz, tbl[i].m, tbl[i].wd, tbl[i].e, tbl[i].lat);

    // reset in the middle of WAIT on the RD_LAT=3 unit
    @(negedge clk);
    mem_word[1] = 64'hFFEEDDCCBBAA9988;
    req_addr[1] = 32'h8003; req_data[1] = 64'h77; req_size[1] = 2'd0; req_valid[1] = 1'b1;
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("abort_rd_strobe", rd_en[1], 1);
    @(negedge clk);
    chk("abort_addr_held", addr64, 32'h8000);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_async_addr", addr64, 32'h0);
    chk("abort_async_flags", {ready[1], rd_en[1], wr_en[1], done[1], err[1]}, 5'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_write", {wr_en[1], done[1]}, 2'b00);
    end
    run_txn(1, 32'h9005, 64'h3C, 2'd0, 64'h0011223344556677, 64'h00113C3344556677, 0, 5);
    run_txn(0, 32'h9003, 64'hC3, 2'd0, 64'hA1B2C3D4,         64'hC3B2C3D4,         0, 3);

    for (int i = 0; i < 120; i++) begin
      s  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      d  = {$urandom, $urandom};
      m  = {$urandom, $urandom};
      model(s, a, d, sz, m, wd, e, lat);
      run_txn(s, a, d, sz, m, wd, e, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
